// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: captures the LED sequence, replays it on
// the buttons, and in modo2 appends a pseudo-random jogada after every round.
module jogador_automatico #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PRESS_CYCLES = 3,
    parameter int unsigned GAP_CYCLES   = 2503,
    parameter int unsigned START_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic       modo2,
    input  logic       erro_en,
    input  logic [3:0] erro_rodada,
    input  logic [3:0] erro_jogada,
    input  logic [3:0] leds,
    input  logic       vez_jogador,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       iniciar,
    output logic       modo2_out,
    output logic [3:0] botoes,
    output logic       terminou,
    output logic       sucesso,
    output logic       overflow,
    output logic [3:0] db_estado,
    output logic [4:0] db_len
);

    localparam logic [4:0]  DEPTH_L   = 5'(DEPTH);
    localparam logic [15:0] PRESS_END = 16'(PRESS_CYCLES - 1);
    localparam logic [15:0] GAP_END   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] START_END = 16'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        DISPARA    = 3'd1,
        CAPTURA    = 3'd2,
        PRESSIONA  = 3'd3,
        SOLTA      = 3'd4,
        GRAVA      = 3'd5,
        ESPERA_VEZ = 3'd6,
        FIM        = 3'd7
    } estado_t;

    estado_t     state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  ptr, ptr_n, len, len_n, i, i_n, idx_next, len_cap;
    logic [3:0]  rodada, rodada_n, lfsr, lfsr_n, botoes_n, leds_q;
    logic [3:0]  mem_first, mem_next, first_val, next_val, grava_val;
    logic [3:0]  waddr, wdata;
    logic        modo2_q, modo2_n, sucesso_n, overflow_n, gap, gap_n, we;
    logic [3:0]  mem [16];

    assign idx_next  = i + 5'd1;
    assign mem_first = mem[0];
    assign mem_next  = mem[idx_next[3:0]];
    assign grava_val = 4'b0001 << lfsr[1:0];
    assign len_cap   = (!modo2_q || rodada == 4'd0) ? ptr : len;

    // Injected error: rotating a one-hot value always yields a different button.
    assign first_val = (erro_en && rodada == erro_rodada && erro_jogada == 4'd0)
                       ? {mem_first[2:0], mem_first[3]} : mem_first;
    assign next_val  = (erro_en && rodada == erro_rodada && idx_next == {1'b0, erro_jogada})
                       ? {mem_next[2:0], mem_next[3]} : mem_next;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 16'd1;
        botoes_n   = botoes;
        i_n        = i;
        ptr_n      = ptr;
        len_n      = len;
        rodada_n   = rodada;
        lfsr_n     = lfsr;
        modo2_n    = modo2_q;
        sucesso_n  = sucesso;
        overflow_n = overflow;
        gap_n      = gap;
        we         = 1'b0;
        waddr      = ptr[3:0];
        wdata      = leds;
        case (state)
            INICIAL, FIM: begin
                botoes_n = '0;
                if (partida) begin
                    state_n    = DISPARA;
                    modo2_n    = modo2;
                    len_n      = '0;
                    rodada_n   = '0;
                    overflow_n = 1'b0;
                    sucesso_n  = 1'b0;
                    cnt_n      = '0;
                end
            end
            DISPARA: begin
                if (cnt == START_END) begin
                    state_n = CAPTURA;
                    ptr_n   = '0;
                    cnt_n   = '0;
                end
            end
            CAPTURA: begin
                if (leds != 4'd0 && leds_q == 4'd0) begin
                    if (ptr < DEPTH_L) begin
                        we    = 1'b1;
                        ptr_n = ptr + 5'd1;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
                if (vez_jogador) begin
                    len_n = len_cap;
                    i_n   = '0;
                    cnt_n = '0;
                    if (len_cap == 5'd0) begin
                        state_n   = FIM;
                        sucesso_n = 1'b0;
                    end else begin
                        state_n  = PRESSIONA;
                        botoes_n = first_val;
                    end
                end
            end
            PRESSIONA: begin
                if (cnt == PRESS_END) begin
                    state_n  = SOLTA;
                    botoes_n = '0;
                    cnt_n    = '0;
                end
            end
            SOLTA: begin
                if (cnt == GAP_END) begin
                    cnt_n = '0;
                    i_n   = idx_next;
                    if (idx_next < len) begin
                        state_n  = PRESSIONA;
                        botoes_n = next_val;
                    end else if (modo2_q) begin
                        state_n  = GRAVA;
                        botoes_n = grava_val;
                        gap_n    = 1'b0;
                    end else begin
                        state_n  = CAPTURA;
                        rodada_n = rodada + 4'd1;
                        ptr_n    = '0;
                    end
                end
            end
            GRAVA: begin
                if (!gap) begin
                    if (cnt == PRESS_END) begin
                        gap_n    = 1'b1;
                        botoes_n = '0;
                        cnt_n    = '0;
                    end
                end else if (cnt == GAP_END) begin
                    if (len < DEPTH_L) begin
                        we    = 1'b1;
                        waddr = len[3:0];
                        wdata = grava_val;
                        len_n = len + 5'd1;
                    end else begin
                        overflow_n = 1'b1;
                    end
                    lfsr_n   = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
                    rodada_n = rodada + 4'd1;
                    state_n  = ESPERA_VEZ;
                    cnt_n    = '0;
                end
            end
            ESPERA_VEZ: begin
                if (vez_jogador) begin
                    state_n  = PRESSIONA;
                    i_n      = '0;
                    botoes_n = first_val;
                    cnt_n    = '0;
                end
            end
            default: state_n = INICIAL;
        endcase
        // Game result wins over whatever press or gap is in flight.
        if (state != INICIAL && state != FIM && (ganhou || perdeu)) begin
            state_n   = FIM;
            botoes_n  = '0;
            sucesso_n = ganhou;
            we        = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INICIAL;
            cnt      <= '0;
            ptr      <= '0;
            len      <= '0;
            i        <= '0;
            rodada   <= '0;
            lfsr     <= 4'b0001;
            botoes   <= '0;
            iniciar  <= 1'b0;
            terminou <= 1'b0;
            modo2_q  <= 1'b0;
            sucesso  <= 1'b0;
            overflow <= 1'b0;
            gap      <= 1'b0;
            leds_q   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
            len      <= len_n;
            i        <= i_n;
            rodada   <= rodada_n;
            lfsr     <= lfsr_n;
            botoes   <= botoes_n;
            iniciar  <= (state_n == DISPARA);
            terminou <= (state_n == FIM);
            modo2_q  <= modo2_n;
            sucesso  <= sucesso_n;
            overflow <= overflow_n;
            gap      <= gap_n;
            leds_q   <= leds;
        end
    end

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign modo2_out = modo2_q;
    assign db_estado = {1'b0, state};
    assign db_len    = len;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a behavioural game model presents sequences,
// checks the replayed presses and exercises error injection, aborts, overflow and reset.
module tb_jogador_automatico;

    localparam int PRESS = 3;
    localparam int GAP   = 13;
    localparam int START = 4;
    localparam int TMO   = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       partida = 1'b0, modo2 = 1'b0, erro_en = 1'b0;
    logic [3:0] erro_rodada = '0, erro_jogada = '0, leds = '0;
    logic       vez_jogador = 1'b0, ganhou = 1'b0, perdeu = 1'b0;
    logic       iniciar, modo2_out, terminou, sucesso, overflow;
    logic [3:0] botoes, db_estado;
    logic [4:0] db_len;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] seq [17];

    jogador_automatico #(
        .DEPTH(16), .PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP), .START_CYCLES(START)
    ) dut (
        .clock(clock), .reset(reset), .partida(partida), .modo2(modo2),
        .erro_en(erro_en), .erro_rodada(erro_rodada), .erro_jogada(erro_jogada),
        .leds(leds), .vez_jogador(vez_jogador), .ganhou(ganhou), .perdeu(perdeu),
        .iniciar(iniciar), .modo2_out(modo2_out), .botoes(botoes),
        .terminou(terminou), .sucesso(sucesso), .overflow(overflow),
        .db_estado(db_estado), .db_len(db_len)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot_rand();
        logic [3:0] one = 4'b0001;
        return one << $urandom_range(3, 0);
    endfunction

    task automatic async_reset(input string tag);
        partida = 0; vez_jogador = 0; leds = '0; ganhou = 0; perdeu = 0;
        #2 reset = 1'b1;
        #1;
        check({tag, " botoes"},    32'(botoes), 32'd0);
        check({tag, " iniciar"},   32'(iniciar), 32'd0);
        check({tag, " terminou"},  32'(terminou), 32'd0);
        check({tag, " db_estado"}, 32'(db_estado), 32'd0);
        check({tag, " db_len"},    32'(db_len), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_game(input logic m);
        int t, n;
        modo2 = m;
        partida = 1; tick(); partida = 0;
        t = 0;
        while (iniciar !== 1'b1 && t < 20) begin tick(); t++; end
        n = 0;
        while (iniciar === 1'b1 && n < 20) begin tick(); n++; end
        check("iniciar length", 32'(n), 32'(START));
        check("modo2_out", 32'(modo2_out), 32'(m));
    endtask

    task automatic show(input int n);
        for (int k = 0; k < n; k++) begin
            leds = seq[k]; tick(); tick();
            leds = '0;     tick(); tick();
        end
    endtask

    task automatic check_end(input string tag, input logic suc, input int len);
        check({tag, " terminou"},  32'(terminou), 32'd1);
        check({tag, " sucesso"},   32'(sucesso), 32'(suc));
        check({tag, " botoes"},    32'(botoes), 32'd0);
        check({tag, " db_estado"}, 32'(db_estado), 32'd7);
        check({tag, " db_len"},    32'(db_len), 32'(len));
    endtask

    // Waits for the next press, then checks gap, value and duration; with abort
    // the game raises perdeu in the second clock of the press.
    task automatic expect_press(input string tag, input logic [3:0] exp,
                                input int min_gap, input int max_gap, input bit abort);
        int t, plen;
        t = 0;
        while (botoes === 4'b0000 && t < TMO) begin tick(); t++; end
        check({tag, " gap"}, 32'((t >= min_gap) && (t <= max_gap)), 32'd1);
        check({tag, " value"}, 32'(botoes), 32'(exp));
        if (abort) begin
            tick();
            perdeu = 1; tick(); perdeu = 0;
            check_end({tag, " abort"}, 1'b0, 32'(db_len));
            check({tag, " abort botoes"}, 32'(botoes), 32'd0);
            return;
        end
        plen = 0;
        while (botoes === exp && plen < TMO) begin tick(); plen++; end
        check({tag, " length"}, 32'(plen), 32'(PRESS));
        check({tag, " release"}, 32'(botoes), 32'd0);
    endtask

    task automatic play_modo1(input int rounds, input int abort_r, input int abort_j);
        logic [3:0] e;
        bit ab;
        for (int r = 1; r <= rounds; r++) begin
            if (r > 1) repeat (GAP + 3) tick();
            if (r == 2) begin partida = 1; tick(); partida = 0; end
            show(r);
            vez_jogador = 1;
            for (int k = 0; k < r; k++) begin
                e  = seq[k];
                ab = (r - 1 == abort_r) && (k == abort_j);
                if (ab) e = {e[2:0], e[3]};
                expect_press($sformatf("m1 r%0d p%0d", r, k), e,
                             (k == 0) ? 0 : GAP, (k == 0) ? TMO : GAP, ab);
                if (k == 0) check($sformatf("m1 r%0d db_len", r), 32'(db_len), 32'(r));
                if (ab) begin vez_jogador = 0; return; end
            end
            vez_jogador = 0;
        end
        ganhou = 1; tick(); ganhou = 0;
        check_end("m1 end", 1'b1, rounds);
    endtask

    task automatic play_modo2();
        logic [3:0] lf, g;
        lf = 4'b0001;
        for (int n = 1; n <= 16; n++) begin
            if (n == 1) begin show(1); vez_jogador = 1; end
            for (int k = 0; k < n; k++) begin
                expect_press($sformatf("m2 r%0d p%0d", n, k), seq[k],
                             (k == 0) ? 0 : GAP, (k == 0) ? TMO : GAP, 1'b0);
                if (k == 0) check($sformatf("m2 r%0d db_len", n), 32'(db_len), 32'(n));
            end
            vez_jogador = 0;
            if (n < 16) begin
                g = 4'b0001 << lf[1:0];
                expect_press($sformatf("m2 grava r%0d", n), g, GAP, GAP, 1'b0);
                seq[n] = g;
                lf = ((lf << 1) | 4'(((lf >> 3) ^ (lf >> 2)) & 4'd1)) & 4'hF;
                vez_jogador = 1;
            end
        end
        ganhou = 1; tick(); ganhou = 0;
        check_end("m2 end", 1'b1, 16);
        check("m2 overflow", 32'(overflow), 32'd0);
    endtask

    initial begin
        int t;
        tick();
        check("reset botoes", 32'(botoes), 32'd0);
        check("reset iniciar", 32'(iniciar), 32'd0);
        check("reset terminou", 32'(terminou), 32'd0);
        check("reset sucesso", 32'(sucesso), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset db_estado", 32'(db_estado), 32'd0);
        check("reset db_len", 32'(db_len), 32'd0);
        reset = 0;
        tick();

        // Modo1 full game
        for (int k = 0; k < 16; k++) seq[k] = onehot_rand();
        start_game(1'b0);
        play_modo1(16, -1, -1);
        check("m1 overflow", 32'(overflow), 32'd0);

        // Modo2 full game
        async_reset("rst before m2");
        seq[0] = 4'b0010;
        start_game(1'b1);
        play_modo2();

        // Error injection at round 5 (0-based), jogada 4
        async_reset("rst before err");
        for (int k = 0; k < 16; k++) seq[k] = onehot_rand();
        seq[4] = 4'b0100;
        erro_en = 1; erro_rodada = 4'd5; erro_jogada = 4'd4;
        start_game(1'b0);
        play_modo1(16, 5, 4);
        check("err db_len", 32'(db_len), 32'd6);
        erro_en = 0;

        // Overflow: 17 LED pulses in one capture
        async_reset("rst before ovf");
        for (int k = 0; k < 17; k++) seq[k] = onehot_rand();
        start_game(1'b0);
        show(17);
        vez_jogador = 1;
        for (int k = 0; k < 16; k++) begin
            expect_press($sformatf("ovf p%0d", k), seq[k],
                         (k == 0) ? 0 : GAP, (k == 0) ? TMO : GAP, 1'b0);
            if (k == 0) begin
                check("ovf flag", 32'(overflow), 32'd1);
                check("ovf db_len", 32'(db_len), 32'd16);
            end
        end
        vez_jogador = 0;
        ganhou = 1; tick(); ganhou = 0;
        check_end("ovf end", 1'b1, 16);
        check("ovf sticky", 32'(overflow), 32'd1);

        // Empty capture ends the game as a defeat, then restart from FIM
        async_reset("rst before empty");
        start_game(1'b0);
        vez_jogador = 1; tick(); vez_jogador = 0;
        check_end("empty", 1'b0, 0);
        partida = 1; tick(); partida = 0;
        check("restart iniciar", 32'(iniciar), 32'd1);
        check("restart terminou", 32'(terminou), 32'd0);
        tick();
        async_reset("rst mid dispara");

        // Reset in the middle of a press
        seq[0] = onehot_rand();
        start_game(1'b0);
        show(1);
        vez_jogador = 1;
        t = 0;
        while (botoes === 4'b0000 && t < TMO) begin tick(); t++; end
        check("midpress value", 32'(botoes), 32'(seq[0]));
        async_reset("rst mid press");

        // Reset in the middle of a gap
        start_game(1'b0);
        show(1);
        vez_jogador = 1;
        expect_press("gap p0", seq[0], 0, TMO, 1'b0);
        vez_jogador = 0;
        repeat (3) tick();
        async_reset("rst mid gap");

        // A later game runs normally
        for (int k = 0; k < 16; k++) seq[k] = onehot_rand();
        start_game(1'b0);
        play_modo1(2, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
